// File: rtl/tinyqv_periph_pkg.sv
// Shared definitions for the TinyQV UART transmitter: register offsets,
// bus transfer-size codes, transmitter state enum and a STATUS packing helper.
package tinyqv_periph_pkg;

  localparam logic [3:0] UART_REG_TXDATA  = 4'h0;
  localparam logic [3:0] UART_REG_STATUS  = 4'h4;
  localparam logic [3:0] UART_REG_DIVIDER = 4'h8;

  // data_write_n / data_read_n encodings
  localparam logic [1:0] XFER_BYTE = 2'b00;
  localparam logic [1:0] XFER_HALF = 2'b01;
  localparam logic [1:0] XFER_WORD = 2'b10;
  localparam logic [1:0] XFER_NONE = 2'b11;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

  // STATUS: bit0 full, bit1 busy, bit2 empty, bits[7:4] FIFO count
  function automatic logic [31:0] uart_status(input logic       full,
                                              input logic       busy,
                                              input logic       empty,
                                              input logic [3:0] count);
    logic [31:0] s;
    s      = '0;
    s[0]   = full;
    s[1]   = busy;
    s[2]   = empty;
    s[7:4] = count;
    return s;
  endfunction

endpackage

// File: rtl/tinyqv_sync_fifo.sv
// Single-clock FIFO with registered occupancy count and combinational head read.
module tinyqv_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;

  assign pop_data = mem[rd_ptr];
  assign count    = count_q;
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tinyqv_uart_tx.sv
// TinyQV memory-mapped UART transmitter: TX FIFO, programmable bit divider,
// 8N1 framing with back-to-back frames and an idle interrupt.
module tinyqv_uart_tx
  import tinyqv_periph_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd103
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        periph_sel,
  input  logic [3:0]  data_addr,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        uart_txd,
  output logic        tx_irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH+1);

  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_dout;
  logic [4:0]    count_ext;
  logic [31:0]   status_word;

  logic          div_wr_lo;
  logic          div_wr_hi;
  logic [15:0]   divider_q;

  uart_state_e   state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          irq_q;

  logic          unused_ok;
  assign unused_ok = &{1'b0, data_in[31:16]};

  tinyqv_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (data_in[7:0]),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign count_ext   = 5'(fifo_count);
  assign status_word = uart_status(fifo_full, state_q != UART_IDLE, fifo_empty, count_ext[3:0]);

  // Bus decode: TXDATA writes stall on a full FIFO, everything else completes at once.
  always_comb begin
    data_ready = 1'b0;
    data_out   = '0;
    push       = 1'b0;
    div_wr_lo  = 1'b0;
    div_wr_hi  = 1'b0;
    if (periph_sel) begin
      if (data_write_n != XFER_NONE) begin
        if (data_addr == UART_REG_TXDATA) begin
          data_ready = !fifo_full;
          push       = !fifo_full;
        end else begin
          data_ready = 1'b1;
          if (data_addr == UART_REG_DIVIDER) begin
            div_wr_lo = 1'b1;
            div_wr_hi = (data_write_n != XFER_BYTE);
          end
        end
      end else if (data_read_n != XFER_NONE) begin
        data_ready = 1'b1;
        case (data_addr)
          UART_REG_STATUS:  data_out = status_word;
          UART_REG_DIVIDER: data_out = {16'h0000, divider_q};
          default:          data_out = '0;
        endcase
      end
    end
  end

  // Divider register; byte writes touch only the low half.
  always_ff @(posedge clk) begin
    if (rst) begin
      divider_q <= DIV_RESET;
    end else begin
      if (div_wr_lo) begin
        divider_q[7:0] <= data_in[7:0];
      end
      if (div_wr_hi) begin
        divider_q[15:8] <= data_in[15:8];
      end
    end
  end

  // Transmitter state register and serial output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UART_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  // Next-state logic: the divider is sampled only when a bit starts, so
  // divider writes mid-bit never change the length of the bit in flight.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state_q)
      UART_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          state_d = UART_START;
          pop     = 1'b1;
          shift_d = fifo_dout;
          baud_d  = divider_q;
          txd_d   = 1'b0;
        end
      end
      UART_START: begin
        if (baud_q == '0) begin
          state_d = UART_DATA;
          idx_d   = '0;
          baud_d  = divider_q;
          txd_d   = shift_q[0];
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      UART_DATA: begin
        if (baud_q == '0) begin
          baud_d = divider_q;
          idx_d  = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = UART_STOP;
            txd_d   = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      UART_STOP: begin
        if (baud_q == '0) begin
          if (!fifo_empty) begin
            state_d = UART_START;
            pop     = 1'b1;
            shift_d = fifo_dout;
            baud_d  = divider_q;
            txd_d   = 1'b0;
          end else begin
            state_d = UART_IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        state_d = UART_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // Idle interrupt, registered: nothing queued and nothing on the wire.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b1;
    end else begin
      irq_q <= fifo_empty && (state_q == UART_IDLE);
    end
  end

  assign uart_txd = txd_q;
  assign tx_irq   = irq_q;

endmodule

// File: tb/tb_tinyqv_uart_tx.sv
// Self-checking bench for tinyqv_uart_tx: expected serial waveforms are built
// from the 8N1 framing rules, expected register values from the register map.
module tb_tinyqv_uart_tx;

  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] DIVR  = 16'd103;

  logic        clk = 1'b0;
  logic        rst;
  logic        periph_sel;
  logic [3:0]  data_addr;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_ready;
  logic        uart_txd;
  logic        tx_irq;

  int checks   = 0;
  int failures = 0;

  bit cap_en = 1'b0;
  bit cap_q[$];
  bit exp_q[$];

  tinyqv_uart_tx #(
    .FIFO_DEPTH (DEPTH),
    .DIV_RESET  (DIVR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .periph_sel   (periph_sel),
    .data_addr    (data_addr),
    .data_write_n (data_write_n),
    .data_read_n  (data_read_n),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_ready   (data_ready),
    .uart_txd     (uart_txd),
    .tx_irq       (tx_irq)
  );

  always #5 clk = ~clk;

  // Serial line recorder, one sample per clock.
  always @(negedge clk) if (cap_en) cap_q.push_back(uart_txd);

  task automatic bus_idle();
    periph_sel   = 1'b0;
    data_addr    = 4'h0;
    data_write_n = 2'b11;
    data_read_n  = 2'b11;
    data_in      = '0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [1:0] sz, input logic [31:0] d,
                           output int stalls, output bit done);
    @(negedge clk);
    periph_sel = 1'b1; data_addr = a; data_write_n = sz; data_read_n = 2'b11; data_in = d;
    stalls = 0; done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      #1;
      if (data_ready === 1'b1) begin done = 1'b1; break; end
      stalls++;
      @(negedge clk);
    end
    if (done) @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output logic rdy);
    @(negedge clk);
    periph_sel = 1'b1; data_addr = a; data_read_n = 2'b10; data_write_n = 2'b11;
    #1;
    d = data_out; rdy = data_ready;
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One 8N1 frame: start bit, 8 data bits LSB first, stop bit.
  function automatic void append_frame(input logic [7:0] b, input int start_len, input int bit_len);
    for (int i = 0; i < start_len; i++) exp_q.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < bit_len; i++) exp_q.push_back(b[k]);
    for (int i = 0; i < bit_len; i++) exp_q.push_back(1'b1);
  endfunction

  // -1: recorded line matches expected stream framed by idle ones; otherwise
  // the index within the stream of the first disagreement (-2: no start bit).
  function automatic int stream_mismatch();
    int i0 = -1;
    for (int i = 0; i < cap_q.size(); i++) if (cap_q[i] == 1'b0) begin i0 = i; break; end
    if (i0 < 0) return -2;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (i0 + k >= cap_q.size()) return k;
      if (cap_q[i0 + k] != exp_q[k]) return k;
    end
    for (int i = i0 + exp_q.size(); i < cap_q.size(); i++)
      if (cap_q[i] != 1'b1) return i - i0;
    return -1;
  endfunction

  task automatic test_reset();
    logic [31:0] d; logic r;
    #1;
    checks++; if (uart_txd !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b want 1", uart_txd); end
    checks++; if (tx_irq !== 1'b1) begin failures++; $display("FAIL reset_irq: got %b want 1", tx_irq); end
    checks++; if (data_ready !== 1'b0 || data_out !== 32'h0) begin failures++;
      $display("FAIL reset_idle_bus: got ready=%b out=%h want 0/0", data_ready, data_out); end
    bus_read(4'h4, d, r);
    checks++; if (d !== 32'h4 || r !== 1'b1) begin failures++;
      $display("FAIL reset_status: got %h/%b want 00000004/1", d, r); end
    bus_read(4'h8, d, r);
    checks++; if (d !== {16'h0, DIVR} || r !== 1'b1) begin failures++;
      $display("FAIL reset_divider: got %h/%b want %h/1", d, r, {16'h0, DIVR}); end
  endtask

  task automatic test_single_frame();
    int s; bit ok; int m;
    bus_write(4'h8, 2'b10, 32'd3, s, ok);
    cap_q.delete(); exp_q.delete(); cap_en = 1'b1;
    bus_write(4'h0, 2'b00, 32'hA5, s, ok);
    checks++; if (!ok || s != 0) begin failures++; $display("FAIL frame_write: done=%b stalls=%0d want 1/0", ok, s); end
    repeat (10) @(negedge clk);
    #1;
    checks++; if (tx_irq !== 1'b0) begin failures++; $display("FAIL frame_irq_busy: got %b want 0", tx_irq); end
    repeat (50) @(negedge clk);
    cap_en = 1'b0;
    append_frame(8'hA5, 4, 4);
    m = stream_mismatch();
    checks++; if (m != -1) begin failures++; $display("FAIL frame_a5_wave: mismatch at %0d want -1 (len %0d)", m, exp_q.size()); end
    #1;
    checks++; if (tx_irq !== 1'b1) begin failures++; $display("FAIL frame_irq_idle: got %b want 1", tx_irq); end
  endtask

  task automatic test_random_frames();
    int s; bit ok; int m; int unsigned dv, n; logic [7:0] b;
    for (int it = 0; it < 4; it++) begin
      dv = $urandom_range(0, 2);
      n  = $urandom_range(1, 3);
      bus_write(4'h8, 2'b01, dv, s, ok);
      cap_q.delete(); exp_q.delete(); cap_en = 1'b1;
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        append_frame(b, dv + 1, dv + 1);
        bus_write(4'h0, 2'b00, {24'h0, b}, s, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rand_write: done=%b want 1", ok); end
      end
      repeat (n * 10 * (dv + 1) + 30) @(negedge clk);
      cap_en = 1'b0;
      m = stream_mismatch();
      checks++; if (m != -1) begin failures++;
        $display("FAIL rand_wave: div=%0d n=%0d mismatch at %0d want -1", dv, n, m); end
    end
  endtask

  task automatic test_back_to_back();
    int s; bit ok; int m; int total; int undone; logic [7:0] b;
    bus_write(4'h8, 2'b10, 32'd0, s, ok);
    cap_q.delete(); exp_q.delete(); cap_en = 1'b1;
    total = 0; undone = 0;
    for (int j = 0; j < DEPTH + 2; j++) begin
      b = 8'($urandom);
      append_frame(b, 1, 1);
      bus_write(4'h0, 2'b00, {24'h0, b}, s, ok);
      total += s;
      if (!ok) undone++;
    end
    checks++; if (undone != 0) begin failures++; $display("FAIL b2b_done: got %0d incomplete want 0", undone); end
    checks++; if (total == 0) begin failures++; $display("FAIL b2b_stall: got %0d stall cycles want >0", total); end
    repeat (90) @(negedge clk);
    cap_en = 1'b0;
    m = stream_mismatch();
    checks++; if (m != -1) begin failures++; $display("FAIL b2b_wave: mismatch at %0d want -1", m); end
    #1;
    checks++; if (tx_irq !== 1'b1) begin failures++; $display("FAIL b2b_irq: got %b want 1", tx_irq); end
  endtask

  task automatic test_status();
    int s; bit ok; logic [31:0] d, e; logic r; int unsigned n, q;
    for (int it = 0; it < 3; it++) begin
      n = (it == 0) ? 3 : $urandom_range(1, DEPTH + 1);
      do_reset();
      bus_write(4'h8, 2'b10, 32'd50, s, ok);
      for (int j = 0; j < n; j++) bus_write(4'h0, 2'b00, 32'($urandom), s, ok);
      repeat (3) @(negedge clk);
      q = n - 1;
      e = (q << 4) | 32'h2 | ((q == 0) ? 32'h4 : 32'h0) | ((q == DEPTH) ? 32'h1 : 32'h0);
      bus_read(4'h4, d, r);
      checks++; if (d !== e || r !== 1'b1) begin failures++;
        $display("FAIL status_queued: n=%0d got %h/%b want %h/1", n, d, r, e); end
    end
    do_reset();
  endtask

  task automatic test_divider();
    int s; bit ok; int m; logic [31:0] d; logic r; logic [7:0] b;
    bus_write(4'h8, 2'b01, 32'h1234, s, ok);
    bus_write(4'h8, 2'b00, 32'hFF, s, ok);
    bus_read(4'h8, d, r);
    checks++; if (d !== 32'h12FF || r !== 1'b1) begin failures++; $display("FAIL div_byte: got %h want 000012ff", d); end
    bus_write(4'h8, 2'b10, 32'hDEADBEEF, s, ok);
    bus_read(4'h8, d, r);
    checks++; if (d !== 32'hBEEF) begin failures++; $display("FAIL div_word: got %h want 0000beef", d); end
    bus_write(4'h8, 2'b10, 32'd3, s, ok);
    b = 8'($urandom);
    cap_q.delete(); exp_q.delete(); cap_en = 1'b1;
    bus_write(4'h0, 2'b00, {24'h0, b}, s, ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (uart_txd === 1'b0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL div_start_seen: got %b want 1", ok); end
    bus_write(4'h8, 2'b10, 32'd7, s, ok);
    append_frame(b, 4, 8);
    repeat (100) @(negedge clk);
    cap_en = 1'b0;
    m = stream_mismatch();
    checks++; if (m != -1) begin failures++; $display("FAIL div_midframe_wave: mismatch at %0d want -1", m); end
  endtask

  task automatic test_reset_mid_frame();
    int s; bit ok; logic [31:0] d; logic r; logic [7:0] b;
    bus_write(4'h8, 2'b10, 32'd3, s, ok);
    b = 8'($urandom) & 8'hF7;
    bus_write(4'h0, 2'b00, {24'h0, b}, s, ok);
    bus_write(4'h0, 2'b00, 32'h5A, s, ok);
    bus_write(4'h0, 2'b00, 32'h3C, s, ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (uart_txd === 1'b0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_start_seen: got %b want 1", ok); end
    repeat (17) @(negedge clk);
    #1;
    checks++; if (uart_txd !== 1'b0) begin failures++; $display("FAIL rstmid_bit3: got %b want 0", uart_txd); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (uart_txd !== 1'b1) begin failures++; $display("FAIL rstmid_txd: got %b want 1", uart_txd); end
    @(negedge clk);
    rst = 1'b0;
    bus_read(4'h4, d, r);
    checks++; if (d !== 32'h4) begin failures++; $display("FAIL rstmid_status: got %h want 00000004", d); end
    bus_read(4'h8, d, r);
    checks++; if (d !== {16'h0, DIVR}) begin failures++; $display("FAIL rstmid_divider: got %h want %h", d, {16'h0, DIVR}); end
    cap_q.delete(); cap_en = 1'b1;
    repeat (40) @(negedge clk);
    cap_en = 1'b0;
    checks++; if (cap_q.sum() with (int'(item)) != cap_q.size()) begin failures++;
      $display("FAIL rstmid_discard: got %0d high of %0d want all high", cap_q.sum() with (int'(item)), cap_q.size()); end
    #1;
    checks++; if (tx_irq !== 1'b1) begin failures++; $display("FAIL rstmid_irq: got %b want 1", tx_irq); end
  endtask

  task automatic test_unselected_unmapped();
    int s; bit ok; logic [31:0] d; logic r;
    @(negedge clk);
    periph_sel = 1'b0; data_addr = 4'h0; data_write_n = 2'b00; data_in = 32'h55;
    #1;
    checks++; if (data_ready !== 1'b0 || data_out !== 32'h0) begin failures++;
      $display("FAIL unsel_tx: got ready=%b out=%h want 0/0", data_ready, data_out); end
    @(negedge clk);
    data_addr = 4'h8; data_write_n = 2'b10; data_in = 32'h9;
    @(negedge clk);
    data_write_n = 2'b11; data_read_n = 2'b10; data_addr = 4'hC;
    #1;
    checks++; if (data_ready !== 1'b0 || data_out !== 32'h0) begin failures++;
      $display("FAIL unsel_read: got ready=%b out=%h want 0/0", data_ready, data_out); end
    bus_idle();
    bus_read(4'hC, d, r);
    checks++; if (d !== 32'h0 || r !== 1'b1) begin failures++; $display("FAIL unmapped_read: got %h/%b want 0/1", d, r); end
    bus_write(4'hC, 2'b10, 32'h11, s, ok);
    checks++; if (!ok || s != 0) begin failures++; $display("FAIL unmapped_write: done=%b stalls=%0d want 1/0", ok, s); end
    repeat (3) @(negedge clk);
    bus_read(4'h4, d, r);
    checks++; if (d !== 32'h4) begin failures++; $display("FAIL unsel_status: got %h want 00000004", d); end
    bus_read(4'h8, d, r);
    checks++; if (d !== {16'h0, DIVR}) begin failures++; $display("FAIL unsel_divider: got %h want %h", d, {16'h0, DIVR}); end
    #1;
    checks++; if (uart_txd !== 1'b1) begin failures++; $display("FAIL unsel_txd: got %b want 1", uart_txd); end
  endtask

  initial begin
    bus_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single_frame();
    test_random_frames();
    test_back_to_back();
    test_status();
    test_divider();
    test_reset_mid_frame();
    test_unselected_unmapped();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
